// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter running on the audio master clock.
// Buffers stereo pairs in a small FIFO, divides mclk down to the bit clock
// and frame clock, and shifts each pair out MSB-first in a 64-bit frame.
// Each 32-bit slot is left-justified and zero-padded after DATA_W bits.
// All pins change only on the cycle where the bit clock falls.
module audio_i2s_tx #(
    parameter int DATA_W     = 16,
    parameter int SCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        mclk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_W-1:0]           tx_left,
    input  logic [DATA_W-1:0]           tx_right,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    input  logic                        underrun_clr,
    output logic                        busy,
    output logic                        i2s_sclk,
    output logic                        i2s_lrclk,
    output logic                        i2s_sdout
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(SCLK_DIV / 2);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Handshake: a stereo pair is accepted on every rising mclk edge where
    // tx_valid and tx_ready are both high. tx_ready is decoded only from the
    // registered fill level, so it never depends on tx_valid in the same cycle.

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Serialiser state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_l_q, shift_l_d;
    logic [DATA_W-1:0] shift_r_q, shift_r_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdout_q, sdout_d;
    logic              underrun_q, underrun_d;

    // Decoded events
    logic              push;
    logic              pop;
    logic              fall;
    logic              frame_start;
    logic              stop;
    logic              ur_set;
    logic [5:0]        bit_nxt;
    logic [DATA_W-1:0] load_l;
    logic [DATA_W-1:0] load_r;
    logic [DATA_W-1:0] cur_l;
    logic [DATA_W-1:0] cur_r;
    logic [DATA_W-1:0] word;
    logic [31:0]       slot_word;
    logic              sdout_bit;

    // Event decode: bit-clock fall, frame boundary, FIFO push/pop, and the data bit for the next slot position
    always_comb begin
        push        = tx_valid && tx_ready;
        fall        = (state_q == RUN) && (div_cnt_q == DIV_LAST);
        bit_nxt     = bit_cnt_q + 6'd1;
        frame_start = fall && (bit_nxt == 6'd0);
        stop        = frame_start && !enable;
        // level_q is registered, so a pair pushed this cycle cannot be popped this cycle
        pop         = frame_start && enable && (level_q != '0);
        ur_set      = frame_start && enable && (level_q == '0);
        load_l      = pop ? mem_l_q[rd_ptr_q] : '0;
        load_r      = pop ? mem_r_q[rd_ptr_q] : '0;
        cur_l       = frame_start ? load_l : shift_l_q;
        cur_r       = frame_start ? load_r : shift_r_q;
        word        = bit_nxt[5] ? cur_r : cur_l;
        // Left-justify the sample in a 32-bit slot; positions past DATA_W read zero padding
        slot_word   = 32'(word) << (32 - DATA_W);
        sdout_bit   = slot_word[5'd31 - bit_nxt[4:0]];
    end

    // FIFO next-state: pointers and fill level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Sticky underrun flag; a clear beats a same-cycle set
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end else if (ur_set) begin
            underrun_d = 1'b1;
        end
    end

    // Serialiser FSM next-state: clock division, bit counting and pin values
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        lrclk_d   = lrclk_q;
        sdout_d   = sdout_q;
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                busy_d    = 1'b0;
                sclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                sdout_d   = 1'b0;
                if (enable) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    bit_cnt_d = 6'd63;
                end
            end
            RUN: begin
                div_cnt_d = fall ? '0 : div_cnt_q + CNT_W'(1);
                sclk_d    = (div_cnt_d >= DIV_HALF);
                if (fall) begin
                    bit_cnt_d = bit_nxt;
                    if (stop) begin
                        // enable is only honoured here, so a started frame always finishes
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        sclk_d  = 1'b0;
                        lrclk_d = 1'b0;
                        sdout_d = 1'b0;
                    end else begin
                        if (frame_start) begin
                            shift_l_d = load_l;
                            shift_r_d = load_r;
                        end
                        // word select leads the first data bit of each slot by one bit
                        lrclk_d = (bit_nxt >= 6'd31) && (bit_nxt <= 6'd62);
                        sdout_d = sdout_bit;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO sample storage; contents need no reset because the pointers are flushed
    always_ff @(posedge mclk) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= tx_left;
            mem_r_q[wr_ptr_q] <= tx_right;
        end
    end

    // State registers with synchronous reset; a reset aborts any frame in progress
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= 6'd63;
            shift_l_q  <= '0;
            shift_r_q  <= '0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdout_q    <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sdout_q    <= sdout_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    assign tx_ready   = (level_q != LVL_FULL);
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign busy       = busy_q;
    assign i2s_sclk   = sclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdout  = sdout_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench for audio_i2s_tx. Instance u_dut uses
// DATA_W=16 / SCLK_DIV=4, instance u_dut_w uses DATA_W=24 / SCLK_DIV=8.
// Frames are captured MSB-first into 64-bit vectors (bit time 0 ends up in
// bit 63) and compared against hand-computed constants.
module tb_audio_i2s_tx;
    // ---------------- clock / reset ----------------
    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic reset;

    // 16-bit instance signals
    logic        enable, tx_valid, tx_ready, underrun, underrun_clr, busy;
    logic [15:0] tx_left, tx_right;
    logic [2:0]  fifo_level;
    logic        i2s_sclk, i2s_lrclk, i2s_sdout;

    // 24-bit instance signals
    logic        enable_w, tx_valid_w, tx_ready_w, underrun_w, underrun_clr_w, busy_w;
    logic [23:0] tx_left_w, tx_right_w;
    logic [2:0]  fifo_level_w;
    logic        i2s_sclk_w, i2s_lrclk_w, i2s_sdout_w;

    audio_i2s_tx #(.DATA_W(16), .SCLK_DIV(4), .FIFO_DEPTH(4)) u_dut (
        .mclk(mclk), .reset(reset), .enable(enable), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_left(tx_left), .tx_right(tx_right),
        .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr),
        .busy(busy), .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_sdout(i2s_sdout)
    );

    audio_i2s_tx #(.DATA_W(24), .SCLK_DIV(8), .FIFO_DEPTH(4)) u_dut_w (
        .mclk(mclk), .reset(reset), .enable(enable_w), .tx_valid(tx_valid_w),
        .tx_ready(tx_ready_w), .tx_left(tx_left_w), .tx_right(tx_right_w),
        .fifo_level(fifo_level_w), .underrun(underrun_w), .underrun_clr(underrun_clr_w),
        .busy(busy_w), .i2s_sclk(i2s_sclk_w), .i2s_lrclk(i2s_lrclk_w), .i2s_sdout(i2s_sdout_w)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sclk_bad = 0;
    int          cnt;
    logic [63:0] sd_vec, lr_vec;

    localparam logic [63:0] LR_FRAME = 64'h0000_0001_FFFF_FFFE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        tx_left  = l;
        tx_right = r;
        tx_valid = 1'b1;
        @(posedge mclk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic start_run(input bit wide);
        if (wide) enable_w = 1'b1;
        else      enable   = 1'b1;
        @(posedge mclk); #1;
    endtask

    task automatic sample_bit(input bit wide);
        sd_vec = {sd_vec[62:0], (wide ? i2s_sdout_w : i2s_sdout)};
        lr_vec = {lr_vec[62:0], (wide ? i2s_lrclk_w : i2s_lrclk)};
    endtask

    // Advance n bit periods; sample pins just after each fall and check the
    // bit clock shape on every mclk edge in between.
    task automatic run_bits(input bit wide, input int n);
        int div;
        logic exp_sclk;
        div = wide ? 8 : 4;
        for (int i = 0; i < n; i++) begin
            for (int k = 1; k <= div; k++) begin
                @(posedge mclk); #1;
                exp_sclk = (k >= div / 2) && (k < div);
                if ((wide ? i2s_sclk_w : i2s_sclk) !== exp_sclk) sclk_bad++;
            end
            sample_bit(wide);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        enable = 1'b0; tx_valid = 1'b0; underrun_clr = 1'b0;
        tx_left = '0; tx_right = '0;
        enable_w = 1'b0; tx_valid_w = 1'b0; underrun_clr_w = 1'b0;
        tx_left_w = '0; tx_right_w = '0;
        sd_vec = '0; lr_vec = '0;
        repeat (3) @(posedge mclk);
        #1;
        check("rst_level", fifo_level, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_underrun", underrun, 0);
        check("rst_busy", busy, 0);
        check("rst_pins", {i2s_sclk, i2s_lrclk, i2s_sdout}, 0);
        check("rst_w_busy", {busy_w, fifo_level_w}, 0);
        reset = 1'b0;
        @(posedge mclk); #1;

        // ---- basic frame ----
        push_pair(16'hA5A5, 16'h3C3C);
        check("basic_level", fifo_level, 1);
        start_run(0);
        check("basic_busy", busy, 1);
        repeat (3) @(posedge mclk);
        #1;
        check("basic_prefall_sd", i2s_sdout, 0);
        @(posedge mclk); #1;
        sample_bit(0);
        check("basic_b0_sd", i2s_sdout, 1);
        check("basic_pop_level", fifo_level, 0);
        run_bits(0, 63);
        check("basic_sd_frame", sd_vec, 64'hA5A5_0000_3C3C_0000);
        check("basic_lr_frame", lr_vec, LR_FRAME);
        enable = 1'b0;
        run_bits(0, 1);
        check("basic_stop_idle", {busy, i2s_sclk, i2s_lrclk, i2s_sdout}, 0);
        check("basic_no_underrun", underrun, 0);

        // ---- underrun ----
        start_run(0);
        repeat (3) @(posedge mclk);
        #1;
        check("ur_before_b0", underrun, 0);
        @(posedge mclk); #1;
        sample_bit(0);
        check("ur_at_b0", underrun, 1);
        run_bits(0, 63);
        check("ur_sd_frame", sd_vec, 0);
        check("ur_lr_frame", lr_vec, LR_FRAME);
        enable = 1'b0;
        run_bits(0, 1);
        check("ur_stop_busy", busy, 0);
        check("ur_sticky", underrun, 1);
        underrun_clr = 1'b1;
        @(posedge mclk); #1;
        underrun_clr = 1'b0;
        check("ur_clr", underrun, 0);
        underrun_clr = 1'b1;
        start_run(0);
        repeat (4) @(posedge mclk);
        #1;
        underrun_clr = 1'b0;
        check("ur_clr_wins", underrun, 0);
        check("ur_clr_busy", busy, 1);
        enable = 1'b0;
        run_bits(0, 64);
        check("ur_clr_stop", busy, 0);

        // ---- graceful stop ----
        push_pair(16'h1234, 16'h5678);
        push_pair(16'h9ABC, 16'hDEF0);
        check("gs_level_pre", fifo_level, 2);
        start_run(0);
        run_bits(0, 11);
        check("gs_level_pop", fifo_level, 1);
        enable = 1'b0;
        run_bits(0, 53);
        check("gs_sd_frame", sd_vec, 64'h1234_0000_5678_0000);
        check("gs_busy_b63", busy, 1);
        run_bits(0, 1);
        check("gs_idle", {busy, i2s_sclk, i2s_lrclk, i2s_sdout}, 0);
        check("gs_level_end", fifo_level, 1);

        // ---- backpressure ----
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        push_pair(16'h5555, 16'h6666);
        check("bp_full_level", fifo_level, 4);
        check("bp_full_ready", tx_ready, 0);
        push_pair(16'h7777, 16'h8888);
        check("bp_5th_ignored", fifo_level, 4);
        tx_left = 16'h7777; tx_right = 16'h8888; tx_valid = 1'b1;
        start_run(0);
        repeat (3) @(posedge mclk);
        #1;
        check("bp_level_prepop", fifo_level, 4);
        @(posedge mclk); #1;
        tx_valid = 1'b0;
        sample_bit(0);
        check("bp_level_pop", fifo_level, 3);
        check("bp_ready_pop", tx_ready, 1);
        run_bits(0, 39);
        check("bp_sd_40bits", sd_vec[39:0], 40'h9ABC0000DE);
        run_bits(0, 1);
        check("rs_pins_b40", {i2s_lrclk, i2s_sdout}, 2'b11);

        // ---- reset mid-frame ----
        reset = 1'b1;
        enable = 1'b0;
        @(posedge mclk); #1;
        check("rs_pins", {i2s_sclk, i2s_lrclk, i2s_sdout}, 0);
        check("rs_level", fifo_level, 0);
        check("rs_busy_ur", {busy, underrun}, 0);
        check("rs_ready", tx_ready, 1);
        reset = 1'b0;
        @(posedge mclk); #1;
        start_run(0);
        run_bits(0, 64);
        check("rs_sd_frame", sd_vec, 0);
        check("rs_lr_frame", lr_vec, LR_FRAME);
        check("rs_underrun", underrun, 1);
        enable = 1'b0;
        run_bits(0, 1);
        check("rs_stop_busy", busy, 0);

        // ---- back-to-back frames, 24-bit / div 8 ----
        tx_left_w = 24'h800001; tx_right_w = 24'h7FFFFE; tx_valid_w = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        start_run(1);
        run_bits(1, 64);
        check("b2b_sd_frame1", sd_vec, 64'h8000_0100_7FFF_FE00);
        check("b2b_lr_frame1", lr_vec, LR_FRAME);
        cnt = 0;
        while (i2s_lrclk_w !== 1'b1 && cnt < 2000) begin
            @(posedge mclk); #1;
            cnt++;
        end
        check("b2b_lr_rise", cnt, 256);
        cnt = 0;
        while (i2s_lrclk_w !== 1'b0 && cnt < 2000) begin
            @(posedge mclk); #1;
            cnt++;
        end
        while (i2s_lrclk_w !== 1'b1 && cnt < 2000) begin
            @(posedge mclk); #1;
            cnt++;
        end
        check("b2b_lr_period", cnt, 512);
        check("b2b_no_underrun", underrun_w, 0);
        check("b2b_level", fifo_level_w, 4);
        tx_valid_w = 1'b0;
        enable_w = 1'b0;
        cnt = 0;
        while (busy_w !== 1'b0 && cnt < 1000) begin
            @(posedge mclk); #1;
            cnt++;
        end
        check("b2b_stop", busy_w, 0);

        check("sclk_duty", sclk_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Audio-side I2S transmitter, clocked by the 12.288 MHz audio master clock `mclk`.
- Divides `mclk` down to the serial bit clock (3.072 MHz at the default divider) and the 48 kHz word-select.
- Serialises stereo samples pushed through a small FIFO, and drives the external codec's SCLK, LRCLK and SDIN pins.

Parameters:
- DATA_W, 16: sample width per channel; 1..32.
- SCLK_DIV, 4: `mclk` cycles per `i2s_sclk` period; even, >=2.
- FIFO_DEPTH, 4: stereo pairs buffered; power of 2, >=2.

Ports:
- mclk  in  1  audio master clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled at frame boundaries.
- tx_valid  in  1  stereo pair valid.
- tx_ready  out  1  FIFO not full.
- tx_left  in  DATA_W  left sample, two's complement.
- tx_right  in  DATA_W  right sample, two's complement.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- underrun  out  1  sticky: a frame started with the FIFO empty.
- underrun_clr  in  1  clears `underrun`.
- busy  out  1  serialiser running.
- i2s_sclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdout  out  1  serial data.

Behaviour:
- Reset (sync, high): FIFO flushed; `fifo_level`=0; `tx_ready`=1; `underrun`=0; `busy`=0; `i2s_sclk`=0; `i2s_lrclk`=0; `i2s_sdout`=0; `div_cnt`=0; `bit_cnt`=63. A reset mid-frame aborts the frame immediately; pins are low on the next cycle.
- FIFO:
  - Push when `tx_valid && tx_ready`.
  - `tx_ready` = (`fifo_level` != FIFO_DEPTH).
  - Push and pop in the same cycle: `level` is unchanged.
  - A push into an empty FIFO is not visible to a pop in the same cycle.
- States: IDLE, RUN.
- IDLE:
  - `div_cnt` is held at 0; pins are held low.
  - On `enable`=1 go to RUN, set `busy`=1, `bit_cnt`=63.
- RUN:
  - `div_cnt` counts 0..SCLK_DIV-1 and wraps.
  - `i2s_sclk` is registered: 1 when `div_cnt` >= SCLK_DIV/2 on the next cycle, else 0.
  - Event "fall" = the cycle where `div_cnt` wraps SCLK_DIV-1 -> 0. The first fall occurs SCLK_DIV cycles after entering RUN.
- On each fall:
  - `bit_cnt` = (`bit_cnt`+1) mod 64; b = new value.
  - If b==0 and `enable`==0: go to IDLE; all pins 0; `busy`=0; no pop. This means the current frame always completes.
  - If b==0 and the FIFO is non-empty: pop; load `shift_l`/`shift_r`.
  - If b==0 and the FIFO is empty: load zeros; set `underrun`.
  - `i2s_lrclk` = 1 for b in 31..62, else 0. It leads the MSB by one bit, per the I2S standard.
  - `i2s_sdout`: slot = b/32, pos = b mod 32.
    - pos < DATA_W: output bit [DATA_W-1-pos] of left (slot 0) or right (slot 1).
    - Otherwise output 0.
  - All pins change only on falls, i.e. while `i2s_sclk` goes low. The codec samples them on the rising edge.
- Frame length: 64 bits = 64*SCLK_DIV `mclk` cycles (256 at the default divider).
- `underrun`:
  - `underrun_clr` wins over a same-cycle set.
  - Otherwise `underrun` holds until reset.
- Output timing: all outputs are registered, except `tx_ready`, which is decoded from the registered `level`.

Test Plan:
- Basic frame (SCLK_DIV=4, DATA_W=16): push L=16'hA5A5, R=16'h3C3C, then assert `enable`.
  - First fall at cycle 4.
  - SDOUT bits 0..15 = A5A5 MSB-first, bits 16..31 = 0, bits 32..47 = 3C3C, bits 48..63 = 0.
  - LRCLK rises at bit 31 and falls at bit 63.
  - SCLK period = 4 cycles, 50% duty.
- Underrun: assert `enable` with the FIFO empty.
  - SDOUT all 0 for the frame; `underrun`=1 from the fall at bit 0.
  - Pulse `underrun_clr` -> 0.
  - Clear and set in the same cycle -> stays 0.
- Backpressure: push 4 pairs with `enable`=0.
  - `fifo_level`=4, `tx_ready`=0; a 5th push is ignored.
  - Enable: first pop at bit 0 -> `level`=3, `tx_ready`=1.
  - Push on that pop cycle is not accepted, because `tx_ready` was 0.
- Graceful stop: deassert `enable` at bit 10 with 2 pairs queued.
  - Frame completes through bit 63; next fall -> IDLE, `busy`=0, pins 0.
  - `fifo_level`=1 (no extra pop).
- Reset mid-frame: assert `reset` at bit 40 with 3 pairs queued.
  - Next cycle: pins 0, `level`=0, `busy`=0, `underrun`=0.
  - Re-enable starts cleanly at bit 0 with an underrun frame.
- Back-to-back frames (SCLK_DIV=8, DATA_W=24): push L=24'h800001, R=24'h7FFFFE, keep `tx_valid` streaming.
  - No underrun; period is 512 cycles per frame.
  - LSB of left at bit 23; pad bits 24..31 = 0.
